fixed_shift_pipe: RTL and testbench
===================================

Name: fixed_shift_pipe

Overview:
- Parametrised successor to the SPU even-pipe simple-fixed-2 unit.
- Executes the SPU shift/rotate family on halfword and word elements, in both register (RR) and 7-bit immediate (RI7) forms.
- Results travel through a configurable-depth delay pipeline to the WB stage. A flush kills all in-flight work on a branch mispredict.
- Sits between the RF/FWD stage and the register-table write port.

Parameters:
- DATA_W, 128: register width in bits; must be a multiple of 32.
- ADDR_W, 7: register-address width.
- LATENCY, 4: cycles from issue to rt_wb; must be ≥ 1.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  11  decoded opcode, left-justified; bit 0 is the MSB.
- format  in  3  0 = RR, 1 = RI7, other values unsupported.
- rt_addr  in  ADDR_W  destination register address.
- ra, rb  in  DATA_W  source operand values; bit 0 is the MSB.
- imm  in  18  immediate; I7 occupies imm[11:17].
- reg_write  in  1  instruction writes the register table.
- flush  in  1  kill all in-flight instructions.
- rt_wb  out  DATA_W  result value.
- rt_addr_wb  out  ADDR_W  destination register for rt_wb.
- reg_write_wb  out  1  rt_wb is to be written.
- busy  out  1  OR of valid bits across all stages.

Behaviour:
- Pipeline structure:
  - Stage registers s[1..LATENCY], each holding {rt, addr, wr}.
  - Outputs are driven directly from s[LATENCY].
  - Inputs are sampled at edge k into s[1]. The result is visible on the outputs after edge k+LATENCY-1.
  - One instruction is accepted per cycle; there is no stall.
- Reset (asynchronous): every stage and every output goes to 0 immediately (rt_wb=0, rt_addr_wb=0, reg_write_wb=0, busy=0).
- Supported opcodes, each with its count rule:
  - format 0:
    - shlh 00001011111: count = rb_half & 0x1F.
    - shl 00001011011: count = rb_word & 0x3F.
    - roth 00001011100: count = rb_half & 0x0F.
    - rot 00001011000: count = rb_word & 0x1F.
  - format 1:
    - shlhi 00001111111: count = I7 & 0x1F.
    - shli 00001111011: count = I7 & 0x3F.
    - rothi 00001111100: count = I7 & 0x0F.
    - roti 00001111000: count = I7 & 0x1F.
  - In the RR forms, the count comes from the same slot of rb as the ra element being operated on.
- Element rules:
  - Halfword ops work on DATA_W/16 independent lanes; word ops work on DATA_W/32 lanes.
  - Shift left: if count < element width, result = elem << count with zero fill; otherwise the result is 0.
  - Rotate: left rotate by count modulo element width.
- Bubbles:
  - nop (format 0, op 0), any unrecognised op/format, or a flush-cycle input inserts a bubble into s[1]: rt=0, addr=0, wr=0.
  - reg_write=0 with a valid op still computes rt and addr but carries wr=0.
- Flush, applied at the edge where flush=1:
  - All of s[1..LATENCY] load bubbles. This includes the instruction being presented in that cycle.
  - The output value present during the flush cycle is already committed and is unaffected in that cycle.
- Flush while reset is asserted: reset dominates.
- reset deasserted mid-stream: the first instruction issued afterwards emerges LATENCY cycles later; no stale data appears.
- LATENCY=1: s[1] drives the outputs directly; flush clears it at the edge.

Decomposition:
- Package spu_fixed_pkg holds:
  - opcode constants (OP_SHLH, OP_SHL, OP_ROTH, OP_ROT, OP_SHLHI, OP_SHLI, OP_ROTHI, OP_ROTI);
  - format enum (FMT_RR=0, FMT_RI7=1);
  - typedef pipe_stage_t {rt, addr, wr}.
- Sub-module elem_shift_rot: parametrised on element width; takes elem, count and rotate flag, returns the result. Instantiated per lane for both 16-bit and 32-bit lanes.

Test Plan:
1. shlh with every ra halfword = 0x8001 and rb halfwords = {1, 15, 16, 0x21, 0, 3, 31, 0xFFE0} → rt_wb halfwords = {0x0002, 0x8000, 0, 0x0002, 0x8001, 0x0008, 0, 0x8001}. rt_addr_wb=5 and reg_write_wb=1 exactly LATENCY cycles after issue.
2. roti with I7=0x24, giving count 4, on ra words = 0x12345678 → each word = 0x23456781. rothi with I7=0x7F, giving count 15, on halfword 0x0001 → 0x8000.
3. Back-to-back shl with counts 31, 32, 63, then nop → words 0x80000000 (ra=1), 0, 0, then a bubble. One result per cycle, in order.
4. Issue 4 instructions, then assert flush during the cycle the 5th is presented → no results from the 2nd–5th instructions ever reach WB. busy=0 on the next cycle.
5. Assert reset asynchronously with 3 valid instructions in flight, mid-cycle → all outputs become 0 before the next edge. After release, a fresh shli emerges at the correct latency.
6. Rebuild with LATENCY=1 and DATA_W=256 → a shlh result appears one edge after issue, and all 16 halfword lanes are correct.

Source files
------------

// File: rtl/spu_fixed_pkg.sv
// Shared opcode, format and pipeline-stage definitions for the SPU simple-fixed shift/rotate unit.
package spu_fixed_pkg;

    localparam int unsigned OP_W       = 11;
    localparam int unsigned DEF_DATA_W = 128;
    localparam int unsigned DEF_ADDR_W = 7;

    localparam logic [OP_W-1:0] OP_SHLH  = 11'b00001011111;
    localparam logic [OP_W-1:0] OP_SHL   = 11'b00001011011;
    localparam logic [OP_W-1:0] OP_ROTH  = 11'b00001011100;
    localparam logic [OP_W-1:0] OP_ROT   = 11'b00001011000;
    localparam logic [OP_W-1:0] OP_SHLHI = 11'b00001111111;
    localparam logic [OP_W-1:0] OP_SHLI  = 11'b00001111011;
    localparam logic [OP_W-1:0] OP_ROTHI = 11'b00001111100;
    localparam logic [OP_W-1:0] OP_ROTI  = 11'b00001111000;

    typedef enum logic [2:0] {
        FMT_RR  = 3'd0,
        FMT_RI7 = 3'd1
    } fmt_e;

    // Stage payload at the default register geometry; the top re-declares it at its own widths.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] rt;
        logic [DEF_ADDR_W-1:0] addr;
        logic                  wr;
    } pipe_stage_t;

endpackage

// File: rtl/elem_shift_rot.sv
// One element lane: left shift with zero fill (saturating to 0 for oversize counts) or left rotate.
module elem_shift_rot #(
    parameter int unsigned EW = 16
) (
    input  logic [EW-1:0]        elem,
    input  logic [$clog2(EW):0]  count,
    input  logic                 rotate,
    output logic [EW-1:0]        result_c
);

    localparam int unsigned SW = $clog2(EW);

    logic [SW-1:0] amt_c;
    logic [EW-1:0] shl_c;

    always_comb begin
        amt_c = count[SW-1:0];
        shl_c = elem << amt_c;
        // The count MSB flags a shift of at least the element width.
        if (rotate) begin
            result_c = shl_c | (elem >> (EW - 32'(amt_c)));
        end else if (count[SW]) begin
            result_c = '0;
        end else begin
            result_c = shl_c;
        end
    end

endmodule

// File: rtl/fixed_shift_pipe.sv
// SPU even-pipe shift/rotate unit: per-lane halfword/word shift and rotate, then a flushable delay line to WB.
module fixed_shift_pipe
    import spu_fixed_pkg::*;
#(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       op,
    input  logic [2:0]        format,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0] ra,
    input  logic [DATA_W-1:0] rb,
    input  logic [17:0]       imm,
    input  logic              reg_write,
    input  logic              flush,
    output logic [DATA_W-1:0] rt_wb,
    output logic [ADDR_W-1:0] rt_addr_wb,
    output logic              reg_write_wb,
    output logic              busy
);

    localparam int unsigned NH = DATA_W / 16;
    localparam int unsigned NW = DATA_W / 32;

    typedef struct packed {
        logic [DATA_W-1:0] rt;
        logic [ADDR_W-1:0] addr;
        logic              wr;
    } stage_t;

    logic              valid_c;
    logic              half_c;
    logic              rot_c;
    logic              imm_c;
    logic [6:0]        i7_c;
    logic [DATA_W-1:0] half_res_c;
    logic [DATA_W-1:0] word_res_c;
    stage_t            s1_c;
    stage_t            pipe_q [LATENCY];
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY:0]  vld_chain_c;
    logic              unused_c;

    assign i7_c = imm[6:0];

    // Opcode decode; anything not recognised becomes a bubble.
    always_comb begin
        valid_c = 1'b1;
        half_c  = 1'b0;
        rot_c   = 1'b0;
        imm_c   = 1'b0;
        if (format == 3'(FMT_RR)) begin
            case (op)
                OP_SHLH: half_c = 1'b1;
                OP_SHL:  ;
                OP_ROTH: begin half_c = 1'b1; rot_c = 1'b1; end
                OP_ROT:  rot_c = 1'b1;
                default: valid_c = 1'b0;
            endcase
        end else if (format == 3'(FMT_RI7)) begin
            imm_c = 1'b1;
            case (op)
                OP_SHLHI: half_c = 1'b1;
                OP_SHLI:  ;
                OP_ROTHI: begin half_c = 1'b1; rot_c = 1'b1; end
                OP_ROTI:  rot_c = 1'b1;
                default:  valid_c = 1'b0;
            endcase
        end else begin
            valid_c = 1'b0;
        end
    end

    for (genvar h = 0; h < int'(NH); h++) begin : g_half
        logic [4:0] src_c;
        logic [4:0] cnt_c;
        always_comb begin
            src_c = imm_c ? i7_c[4:0] : rb[16*h +: 5];
            cnt_c = rot_c ? {1'b0, src_c[3:0]} : src_c;
        end
        elem_shift_rot #(.EW(16)) u_lane (
            .elem     (ra[16*h +: 16]),
            .count    (cnt_c),
            .rotate   (rot_c),
            .result_c (half_res_c[16*h +: 16])
        );
    end

    for (genvar w = 0; w < int'(NW); w++) begin : g_word
        logic [5:0] src_c;
        logic [5:0] cnt_c;
        always_comb begin
            src_c = imm_c ? i7_c[5:0] : rb[32*w +: 6];
            cnt_c = rot_c ? {1'b0, src_c[4:0]} : src_c;
        end
        elem_shift_rot #(.EW(32)) u_lane (
            .elem     (ra[32*w +: 32]),
            .count    (cnt_c),
            .rotate   (rot_c),
            .result_c (word_res_c[32*w +: 32])
        );
    end

    // Stage-1 payload; an input presented alongside flush is dropped.
    always_comb begin
        s1_c = '0;
        if (valid_c && !flush) begin
            s1_c.rt   = half_c ? half_res_c : word_res_c;
            s1_c.addr = rt_addr;
            s1_c.wr   = reg_write;
        end
    end

    assign vld_chain_c = {vld_q, valid_c};
    assign unused_c    = ^{imm[17:7], rb, vld_chain_c[LATENCY]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            for (int i = 0; i < int'(LATENCY); i++) pipe_q[i] <= '0;
            vld_q <= '0;
            busy  <= 1'b0;
        end else begin
            pipe_q[0] <= s1_c;
            for (int i = 1; i < int'(LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
            vld_q <= vld_chain_c[LATENCY-1:0];
            busy  <= |vld_chain_c[LATENCY-1:0];
        end
    end

    assign rt_wb        = pipe_q[LATENCY-1].rt;
    assign rt_addr_wb   = pipe_q[LATENCY-1].addr;
    assign reg_write_wb = pipe_q[LATENCY-1].wr;

endmodule

// File: tb/tb_fixed_shift_pipe.sv
// Scoreboard bench: default build (128b, latency 4) plus a 256b latency-1 build.
module tb_fixed_shift_pipe;
    import spu_fixed_pkg::*;

    localparam int unsigned LAT1 = 4;
    localparam int unsigned LAT2 = 1;

    typedef struct {
        int         due;
        logic [255:0] rt;
        logic [6:0] addr;
        logic       wr;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q1[$];
    exp_t q2[$];

    logic [10:0]  op;     logic [2:0]   format;  logic [6:0] rt_addr;
    logic [127:0] ra, rb; logic [17:0]  imm;     logic reg_write, flush;
    logic [127:0] rt_wb;  logic [6:0]   rt_addr_wb; logic reg_write_wb, busy;

    logic [10:0]  op2;     logic [2:0]   fmt2;   logic [6:0] addr2;
    logic [255:0] ra2, rb2; logic [17:0] imm2;   logic wr2, flush2;
    logic [255:0] rt_wb2;  logic [6:0]   addr_wb2; logic wr_wb2, busy2;

    fixed_shift_pipe #(.DATA_W(128), .ADDR_W(7), .LATENCY(LAT1)) dut1 (
        .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
        .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write), .flush(flush),
        .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb), .busy(busy)
    );

    fixed_shift_pipe #(.DATA_W(256), .ADDR_W(7), .LATENCY(LAT2)) dut2 (
        .clk(clk), .reset(reset), .op(op2), .format(fmt2), .rt_addr(addr2),
        .ra(ra2), .rb(rb2), .imm(imm2), .reg_write(wr2), .flush(flush2),
        .rt_wb(rt_wb2), .rt_addr_wb(addr_wb2), .reg_write_wb(wr_wb2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [271:0] act, input logic [271:0] e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, e);
        end
    endtask

    // Monitors: pop the due entry, otherwise the WB port must be a bubble.
    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0 && q1[0].due < cyc) begin
            check("wb1_missing", 272'(cyc), 272'(q1[0].due));
            void'(q1.pop_front());
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            check("wb1", 272'({rt_wb, rt_addr_wb, reg_write_wb}), 272'({e.rt[127:0], e.addr, e.wr}));
        end else begin
            check("bubble1", 272'({rt_wb, rt_addr_wb, reg_write_wb}), 272'(0));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q2.size() > 0 && q2[0].due < cyc) begin
            check("wb2_missing", 272'(cyc), 272'(q2[0].due));
            void'(q2.pop_front());
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            e = q2.pop_front();
            check("wb2", 272'({rt_wb2, addr_wb2, wr_wb2}), 272'({e.rt, e.addr, e.wr}));
        end else begin
            check("bubble2", 272'({rt_wb2, addr_wb2, wr_wb2}), 272'(0));
        end
    end

    task automatic issue1(input logic [10:0] o, input logic [2:0] f, input logic [6:0] a,
                          input logic [127:0] x, input logic [127:0] y, input logic [17:0] im,
                          input logic w, input logic fl, input logic has, input logic [127:0] e);
        @(posedge clk); #1;
        op = o; format = f; rt_addr = a; ra = x; rb = y; imm = im; reg_write = w; flush = fl;
        if (has) q1.push_back('{due: cyc + int'(LAT1), rt: 256'(e), addr: a, wr: w});
        if (fl) while (q1.size() > 0 && q1[q1.size()-1].due > cyc) void'(q1.pop_back());
    endtask

    task automatic issue2(input logic [10:0] o, input logic [2:0] f, input logic [6:0] a,
                          input logic [255:0] x, input logic [255:0] y, input logic [17:0] im,
                          input logic w, input logic fl, input logic has, input logic [255:0] e);
        @(posedge clk); #1;
        op2 = o; fmt2 = f; addr2 = a; ra2 = x; rb2 = y; imm2 = im; wr2 = w; flush2 = fl;
        if (has) q2.push_back('{due: cyc + int'(LAT2), rt: e, addr: a, wr: w});
        if (fl) while (q2.size() > 0 && q2[q2.size()-1].due > cyc) void'(q2.pop_back());
    endtask

    task automatic nop1(input int n);
        for (int i = 0; i < n; i++) issue1(11'd0, 3'd0, 7'd0, '0, '0, 18'd0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic nop2(input int n);
        for (int i = 0; i < n; i++) issue2(11'd0, 3'd0, 7'd0, '0, '0, 18'd0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        op = '0; format = '0; rt_addr = '0; ra = '0; rb = '0; imm = '0; reg_write = 1'b0; flush = 1'b0;
        op2 = '0; fmt2 = '0; addr2 = '0; ra2 = '0; rb2 = '0; imm2 = '0; wr2 = 1'b0; flush2 = 1'b0;
        #2;
        check("reset_outputs", 272'({rt_wb, rt_addr_wb, reg_write_wb, busy}), 272'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // shlh with saturating and masked per-lane counts
        issue1(OP_SHLH, 3'd0, 7'd5, {8{16'h8001}},
               {16'h0001, 16'h000F, 16'h0010, 16'h0021, 16'h0000, 16'h0003, 16'h001F, 16'hFFE0},
               18'd0, 1'b1, 1'b0, 1'b1,
               {16'h0002, 16'h8000, 16'h0000, 16'h0002, 16'h8001, 16'h0008, 16'h0000, 16'h8001});
        // immediate rotates; upper imm bits must be ignored
        issue1(OP_ROTI,  3'd1, 7'd7, {4{32'h12345678}}, '0, 18'h3FF24, 1'b1, 1'b0, 1'b1, {4{32'h23456781}});
        issue1(OP_ROTHI, 3'd1, 7'd8, {8{16'h0001}},     '0, 18'h0007F, 1'b1, 1'b0, 1'b1, {8{16'h8000}});
        // back-to-back word shifts at the width boundary, then a bubble
        issue1(OP_SHL, 3'd0, 7'd1, {4{32'h1}}, {4{32'd31}}, 18'd0, 1'b1, 1'b0, 1'b1, {4{32'h80000000}});
        issue1(OP_SHL, 3'd0, 7'd2, {4{32'h1}}, {4{32'd32}}, 18'd0, 1'b1, 1'b0, 1'b1, '0);
        issue1(OP_SHL, 3'd0, 7'd3, {4{32'h1}}, {4{32'd63}}, 18'd0, 1'b1, 1'b0, 1'b1, '0);
        nop1(1);
        issue1(OP_SHL, 3'd0, 7'd4, {4{32'h1}}, {32'd31, 32'd32, 32'd63, 32'd64}, 18'd0, 1'b1, 1'b0, 1'b1,
               {32'h80000000, 32'h0, 32'h0, 32'h1});
        issue1(OP_ROT,  3'd0, 7'd6, {4{32'h80000001}}, {4{32'h21}},   18'd0, 1'b1, 1'b0, 1'b1, {4{32'h3}});
        issue1(OP_ROTH, 3'd0, 7'd9, {8{16'h9001}},     {8{16'h0013}}, 18'd0, 1'b1, 1'b0, 1'b1, {8{16'h800C}});
        issue1(OP_SHLI, 3'd1, 7'd11, {4{32'h3}}, '0, 18'h00045, 1'b0, 1'b0, 1'b1, {4{32'h60}});
        issue1(OP_SHLHI, 3'd1, 7'd12, {8{16'hFFFF}}, '0, 18'h00011, 1'b1, 1'b0, 1'b1, '0);
        // unsupported format/opcode combinations are bubbles
        issue1(OP_SHLH, 3'd2, 7'd13, {8{16'h1}}, {8{16'h1}}, 18'd1, 1'b1, 1'b0, 1'b0, '0);
        issue1(OP_SHLH, 3'd1, 7'd14, {8{16'h1}}, {8{16'h1}}, 18'd1, 1'b1, 1'b0, 1'b0, '0);
        issue1(OP_SHLI, 3'd0, 7'd15, {8{16'h1}}, {8{16'h1}}, 18'd1, 1'b1, 1'b0, 1'b0, '0);
        nop1(6);

        // flush: only the first of five reaches WB
        issue1(OP_SHL, 3'd0, 7'd10, {4{32'h1}}, {4{32'd1}}, 18'd0, 1'b1, 1'b0, 1'b1, {4{32'h2}});
        issue1(OP_SHL, 3'd0, 7'd11, {4{32'h1}}, {4{32'd2}}, 18'd0, 1'b1, 1'b0, 1'b1, {4{32'h4}});
        issue1(OP_SHL, 3'd0, 7'd12, {4{32'h1}}, {4{32'd3}}, 18'd0, 1'b1, 1'b0, 1'b1, {4{32'h8}});
        issue1(OP_SHL, 3'd0, 7'd13, {4{32'h1}}, {4{32'd4}}, 18'd0, 1'b1, 1'b0, 1'b1, {4{32'h10}});
        issue1(OP_SHL, 3'd0, 7'd14, {4{32'h1}}, {4{32'd5}}, 18'd0, 1'b1, 1'b1, 1'b0, '0);
        check("busy_before_flush", 272'(busy), 272'(1));
        nop1(1);
        check("busy_after_flush", 272'(busy), 272'(0));
        nop1(5);

        // asynchronous reset mid-cycle with work in flight
        issue1(OP_SHL, 3'd0, 7'd20, {4{32'h1}}, {4{32'd6}}, 18'd0, 1'b1, 1'b0, 1'b1, {4{32'h40}});
        issue1(OP_SHL, 3'd0, 7'd21, {4{32'h1}}, {4{32'd7}}, 18'd0, 1'b1, 1'b0, 1'b1, {4{32'h80}});
        issue1(OP_SHL, 3'd0, 7'd22, {4{32'h1}}, {4{32'd8}}, 18'd0, 1'b1, 1'b0, 1'b1, {4{32'h100}});
        issue1(OP_SHL, 3'd0, 7'd23, {4{32'h1}}, {4{32'd9}}, 18'd0, 1'b1, 1'b0, 1'b1, {4{32'h200}});
        nop1(1);
        #2;
        check("pre_reset_wb", 272'({rt_wb, rt_addr_wb, reg_write_wb, busy}),
              272'({{4{32'h40}}, 7'd20, 1'b1, 1'b1}));
        reset = 1'b1;
        q1.delete();
        #1;
        check("async_reset", 272'({rt_wb, rt_addr_wb, reg_write_wb, busy}), 272'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        issue1(OP_SHLI, 3'd1, 7'd30, {4{32'h40000000}}, '0, 18'h00041, 1'b1, 1'b0, 1'b1, {4{32'h80000000}});
        nop1(6);

        // 256-bit, latency-1 build: all 16 halfword lanes
        issue2(OP_SHLH, 3'd0, 7'd5, {16{16'h8001}},
               {16'h0001, 16'h000F, 16'h0010, 16'h0021, 16'h0000, 16'h0003, 16'h001F, 16'hFFE0,
                16'h0002, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h000E, 16'h0011},
               18'd0, 1'b1, 1'b0, 1'b1,
               {16'h0002, 16'h8000, 16'h0000, 16'h0002, 16'h8001, 16'h0008, 16'h0000, 16'h8001,
                16'h0004, 16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h0100, 16'h4000, 16'h0000});
        issue2(OP_SHL, 3'd0, 7'd3, {8{32'h1}}, {8{32'd4}}, 18'd0, 1'b1, 1'b0, 1'b1, {8{32'h10}});
        issue2(OP_ROT, 3'd0, 7'd4, {8{32'h1}}, {8{32'd4}}, 18'd0, 1'b1, 1'b1, 1'b0, '0);
        nop2(1);
        check("busy2_after_flush", 272'(busy2), 272'(0));
        nop2(3);

        check("drain_q1", 272'(q1.size()), 272'(0));
        check("drain_q2", 272'(q2.size()), 272'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
